// File: rtl/fl_pkg.sv
// rtl/fl_pkg.sv - shared rename/free-list widths and constants
package fl_pkg;

  localparam int PR_WIDTH     = 7;
  localparam int NUM_PR       = 64;
  localparam int NUM_AR       = 32;
  localparam int FL_DEPTH     = 32;
  localparam int FL_PTR_WIDTH = 5;
  localparam int CNT_WIDTH    = FL_PTR_WIDTH + 1;

  localparam logic [PR_WIDTH-1:0] ZERO_REG = '0;

endpackage

// File: rtl/fl.sv
// rtl/fl.sv - circular free list of PR tags; FL_BYPASS_EN forwards same-cycle retired tags
module fl
  import fl_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic [1:0]          id_dispatch_num,
  input  logic                id_valid_inst0,
  input  logic                id_valid_inst1,
  input  logic [1:0]          rob_retire_num,
  input  logic [PR_WIDTH-1:0] rob_retire_told0,
  input  logic [PR_WIDTH-1:0] rob_retire_told1,
  input  logic                recover,
  output logic [PR_WIDTH-1:0] fl_pr0,
  output logic [PR_WIDTH-1:0] fl_pr1,
  output logic [1:0]          fl_avail_num
);

  logic [PR_WIDTH-1:0]     entry [FL_DEPTH];
  logic [FL_PTR_WIDTH-1:0] head, tail, retire_head;
  logic [FL_PTR_WIDTH-1:0] head_p1, tail_p1;
  logic [CNT_WIDTH-1:0]    count;
  logic                    alloc0, alloc1;
  logic [1:0]              alloc_num, buf_num, fwd_num, pop_num, push_num;
  logic [2:0]              avail_sum;
  logic [PR_WIDTH-1:0]     cand0, cand1, wr0;

  // Slot allocation decode, tag selection and how many tags each side moves
  always_comb begin
    alloc0    = (id_dispatch_num != 2'd0) && id_valid_inst0;
    alloc1    = (id_dispatch_num > 2'd1) && id_valid_inst1;
    alloc_num = {1'b0, alloc0} + {1'b0, alloc1};
    head_p1   = head + FL_PTR_WIDTH'(1);
    tail_p1   = tail + FL_PTR_WIDTH'(1);
    buf_num   = (count >= CNT_WIDTH'(2)) ? 2'd2 : count[1:0];
    cand0     = entry[head];
    cand1     = entry[head_p1];
    fwd_num   = 2'd0;
    avail_sum = {1'b0, buf_num};
`ifdef FL_BYPASS_EN
    // Retired tags queue up behind whatever is still buffered
    if (count == CNT_WIDTH'(0)) begin
      cand0 = rob_retire_told0;
      cand1 = rob_retire_told1;
    end else if (count == CNT_WIDTH'(1)) begin
      cand1 = rob_retire_told0;
    end
    avail_sum = {1'b0, buf_num} + {1'b0, rob_retire_num};
    if (alloc_num > buf_num)
      fwd_num = alloc_num - buf_num;
`endif
    fl_avail_num = (avail_sum >= 3'd2) ? 2'd2 : avail_sum[1:0];
    fl_pr0       = cand0;
    fl_pr1       = alloc0 ? cand1 : cand0;
    // Forwarded tags bypass storage: fewer buffered pops and fewer pushes
    pop_num      = alloc_num - fwd_num;
    push_num     = rob_retire_num - fwd_num;
    wr0          = (fwd_num == 2'd0) ? rob_retire_told0 : rob_retire_told1;
  end

  // Pointer/count/storage update; recovery rewinds head to the retire point
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < FL_DEPTH; i++)
        entry[i] <= PR_WIDTH'(FL_DEPTH + i);
      head        <= '0;
      tail        <= '0;
      retire_head <= '0;
      count       <= CNT_WIDTH'(FL_DEPTH);
    end else if (recover) begin
      head  <= retire_head;
      count <= CNT_WIDTH'(FL_DEPTH);
    end else begin
      head        <= head + FL_PTR_WIDTH'(pop_num);
      tail        <= tail + FL_PTR_WIDTH'(push_num);
      retire_head <= retire_head + FL_PTR_WIDTH'(push_num);
      count       <= count + CNT_WIDTH'(rob_retire_num) - CNT_WIDTH'(alloc_num);
      if (push_num != 2'd0)
        entry[tail] <= wr0;
      if (push_num == 2'd2)
        entry[tail_p1] <= rob_retire_told1;
    end
  end

endmodule

// File: tb/tb_fl.sv
// tb/tb_fl.sv - scoreboard bench for the free list against a queue model
module tb_fl;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] id_dispatch_num;
  logic       id_valid_inst0, id_valid_inst1;
  logic [1:0] rob_retire_num;
  logic [6:0] rob_retire_told0, rob_retire_told1;
  logic       recover;
  logic [6:0] fl_pr0, fl_pr1;
  logic [1:0] fl_avail_num;

  int checks = 0;
  int failures = 0;

  // free_q: free tags in allocation order; rob_q: allocated, not yet retired; arch_q: committed
  int free_q[$];
  int rob_q[$];
  int arch_q[$];

  typedef struct { int slot; int tag; } exp_t;
  exp_t sb[$];

  always #5 clock = ~clock;

  fl dut (
    .clock            (clock),
    .reset            (reset),
    .id_dispatch_num  (id_dispatch_num),
    .id_valid_inst0   (id_valid_inst0),
    .id_valid_inst1   (id_valid_inst1),
    .rob_retire_num   (rob_retire_num),
    .rob_retire_told0 (rob_retire_told0),
    .rob_retire_told1 (rob_retire_told1),
    .recover          (recover),
    .fl_pr0           (fl_pr0),
    .fl_pr1           (fl_pr1),
    .fl_avail_num     (fl_avail_num)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    free_q.delete(); rob_q.delete(); arch_q.delete(); sb.delete();
    for (int i = 0; i < 32; i++) begin
      arch_q.push_back(i);
      free_q.push_back(32 + i);
    end
  endtask

  task automatic arch_remove(input int t);
    int idx[$];
    idx = arch_q.find_first_index(x) with (x == t);
    if (idx.size() != 0) arch_q.delete(idx[0]);
  endtask

  function automatic int model_avail(input int rn);
    int a;
`ifdef FL_BYPASS_EN
    a = free_q.size() + rn;
`else
    a = free_q.size();
`endif
    return (a > 2) ? 2 : a;
  endfunction

  task automatic idle_inputs();
    id_dispatch_num = 2'd0; id_valid_inst0 = 1'b0; id_valid_inst1 = 1'b0;
    rob_retire_num = 2'd0; rob_retire_told0 = 7'd0; rob_retire_told1 = 7'd0;
    recover = 1'b0;
  endtask

  task automatic do_reset(input bit rec);
    idle_inputs();
    reset = 1'b1; recover = rec;
    @(posedge clock); #1;
    reset = 1'b0; recover = 1'b0;
    model_reset();
    @(negedge clock);
    chk("rst_pr0", fl_pr0, 32);
    chk("rst_avail", fl_avail_num, 2);
    chk("rst_count", dut.count, 32);
    chk("rst_head", dut.head, 0);
    chk("rst_tail", dut.tail, 0);
    @(posedge clock); #1;
  endtask

  // One cycle: drive, predict, compare outputs at negedge, then compare count after the edge
  task automatic step(input int dn, input bit v0, input bit v1, input int rn,
                      input int t0, input int t1, input bit rec);
    bit   a0, a1;
    int   avail, obs;
    exp_t e;
    int   alloc_tags[$];
    int   hits[$];
    a0 = (dn > 0) && v0;
    a1 = (dn > 1) && v1;
    id_dispatch_num = 2'(dn); id_valid_inst0 = v0; id_valid_inst1 = v1;
    rob_retire_num = 2'(rn); rob_retire_told0 = 7'(t0); rob_retire_told1 = 7'(t1);
    recover = rec;
    avail = model_avail(rn);
    if (!rec) begin
      if (int'(a0) + int'(a1) > avail) begin
        failures++;
        $display("FAIL illegal_stimulus alloc=%0d avail=%0d", int'(a0) + int'(a1), avail);
      end
`ifdef FL_BYPASS_EN
      if (rn > 0) free_q.push_back(t0);
      if (rn > 1) free_q.push_back(t1);
`endif
      if (a0) begin e.slot = 0; e.tag = free_q.pop_front(); sb.push_back(e); end
      if (a1) begin e.slot = 1; e.tag = free_q.pop_front(); sb.push_back(e); end
`ifndef FL_BYPASS_EN
      if (rn > 0) free_q.push_back(t0);
      if (rn > 1) free_q.push_back(t1);
`endif
      if (rn > 0) arch_remove(t0);
      if (rn > 1) arch_remove(t1);
      for (int k = 0; k < rn; k++) arch_q.push_back(rob_q.pop_front());
    end
    @(negedge clock);
    if (!rec) chk("avail", fl_avail_num, avail);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      obs = (e.slot == 0) ? int'(fl_pr0) : int'(fl_pr1);
      chk(e.slot == 0 ? "pr0" : "pr1", obs, e.tag);
      hits = rob_q.find_index(x) with (x == obs);
      chk("no_dup", hits.size(), 0);
      alloc_tags.push_back(e.tag);
    end
    foreach (alloc_tags[i]) rob_q.push_back(alloc_tags[i]);
    if (rec) begin
      free_q = {rob_q, free_q};
      rob_q.delete();
    end
    @(posedge clock); #1;
    chk("count", dut.count, 32 - rob_q.size());
    idle_inputs();
  endtask

  initial begin
    int dn, rn, t0, t1, i0, i1, av;
    bit v0, v1, rec;
    reset = 1'b1;
    idle_inputs();

    // Reset state, then a full two-slot dispatch
    do_reset(1'b0);
    step(2, 1, 1, 0, 0, 0, 0);
    chk("r22_count", dut.count, 30);
    step(1, 1, 0, 0, 0, 0, 0);

    // Only slot1 valid: takes the head tag, head moves by one
    do_reset(1'b0);
    step(2, 0, 1, 0, 0, 0, 0);
    chk("r23_head", dut.head, 1);
    chk("r23_count", dut.count, 31);

    // Drain everything, then refill via retirement with pointer wrap
    do_reset(1'b0);
    repeat (16) step(2, 1, 1, 0, 0, 0, 0);
    chk("r24_empty", dut.count, 0);
    step(0, 0, 0, 2, 5, 9, 0);
    chk("r24_tail", dut.tail, 2);
    step(2, 1, 1, 0, 0, 0, 0);

    // Recovery returns in-flight tags; retire inputs on that cycle ignored
    do_reset(1'b0);
    repeat (3) step(2, 1, 1, 0, 0, 0, 0);
    step(0, 0, 0, 2, 3, 4, 0);
    step(2, 1, 1, 2, 1, 2, 1);
    chk("r25_head", dut.head, 2);
    chk("r25_tail", dut.tail, 2);
    step(1, 1, 0, 0, 0, 0, 0);

    // One buffered tag, one retiring tag, two dispatch slots requested
    do_reset(1'b0);
    repeat (15) step(2, 1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    chk("r26_hold", dut.count, 1);
`ifdef FL_BYPASS_EN
    step(2, 1, 1, 1, 7, 0, 0);
    chk("r26_count", dut.count, 0);
`else
    step(1, 1, 0, 1, 7, 0, 0);
    chk("r26_count", dut.count, 1);
`endif

    // Random legal traffic against the queue model
    do_reset(1'b0);
    for (int c = 0; c < 200; c++) begin
`ifdef FL_BYPASS_EN
      rec = 1'b0;
`else
      rec = ($urandom_range(0, 19) == 0);
`endif
      rn = $urandom_range(0, 2);
      if (rn > rob_q.size()) rn = rob_q.size();
      i0 = $urandom_range(0, arch_q.size() - 1);
      i1 = (i0 + 1 + $urandom_range(0, arch_q.size() - 2)) % arch_q.size();
      t0 = arch_q[i0];
      t1 = arch_q[i1];
      av = model_avail(rn);
      dn = $urandom_range(0, 2);
      v0 = 1'($urandom);
      v1 = 1'($urandom);
      if (int'((dn > 0) && v0) + int'((dn > 1) && v1) > av) v1 = 1'b0;
      if (int'((dn > 0) && v0) + int'((dn > 1) && v1) > av) v0 = 1'b0;
      step(dn, v0, v1, rn, t0, t1, rec);
    end

    // Reset mid-operation, together with recover
    step(2, 1, 1, 0, 0, 0, 0);
    do_reset(1'b1);
    step(2, 1, 1, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fl.md
FL -- requirements
Module: fl

Interface
REQ-001 SHALL have ports: clock in 1 (system clock); reset in 1 (synchronous, active-high).
REQ-002 SHALL have inputs: id_dispatch_num 2, slots dispatched this cycle (0..2); id_valid_inst0 and id_valid_inst1, 1 each, slot holds a renaming instruction.
REQ-003 SHALL have inputs: rob_retire_num 2, instructions retiring this cycle (0..2); rob_retire_told0 and rob_retire_told1, 7 each, old PR tags freed by retirement.
REQ-004 SHALL have input recover 1, exception/mispredict flush.
REQ-005 SHALL have outputs: fl_pr0 and fl_pr1, 7 each, new PR tags for slot0/slot1; fl_avail_num 2, free tags available, min(count,2).

Function
REQ-006 SHALL hold a 32-entry circular buffer of 7-bit PR tags, with 5-bit head, tail and retire_head pointers wrapping mod 32, and a 6-bit count (0..32).
REQ-007 SHALL define alloc0 = (id_dispatch_num>0)&id_valid_inst0 and alloc1 = (id_dispatch_num>1)&id_valid_inst1.
REQ-008 SHALL drive fl_pr0 = entry[head], and fl_pr1 = entry[head+1] if alloc0 else entry[head], combinationally.
REQ-009 SHALL, when not recover, advance head by alloc0+alloc1 and write each retired told to entry[tail], entry[tail+1] in order.
REQ-010 SHALL, when not recover, advance tail and retire_head by rob_retire_num.
REQ-011 SHALL update count_next = count + rob_retire_num - (alloc0+alloc1), with simultaneous push and pop permitted.
REQ-012 SHALL treat an allocation exceeding fl_avail_num, or a push with count+retires>32, as illegal input; in that case state is undefined and the bench flags it.
REQ-013 SHALL, on recover, ignore dispatch and retire inputs and set head <= retire_head and count <= 32, returning all in-flight tags.
REQ-014 SHALL have zero-cycle allocation latency: tags pushed at edge N become allocatable from cycle N+1.

Reset
REQ-015 SHALL on reset set entry[i] = 32+i for i=0..31, head=tail=retire_head=0 and count=32, so that fl_pr0=32, fl_pr1=33 (alloc0=1) and fl_avail_num=2.
REQ-016 SHALL give reset priority over recover, and SHALL let a reset asserted mid-operation discard all pending state in one cycle.

Configuration
REQ-017 SHALL support macro FL_BYPASS_EN.
REQ-018 With FL_BYPASS_EN defined: when count<2, same-cycle retired told tags SHALL be counted in fl_avail_num and forwarded to fl_pr0/fl_pr1 in slot order after buffered entries; forwarded tags SHALL be consumed and not written into the buffer.
REQ-019 Without FL_BYPASS_EN: fl_avail_num and fl_pr0/fl_pr1 SHALL depend on buffered entries only.

Structure
REQ-020 Shared definitions header SHALL hold PR_WIDTH=7, NUM_PR=64, NUM_AR=32, FL_DEPTH=32 and FL_PTR_WIDTH=5, together with the existing ZERO_REG.
REQ-021 SHALL be a single module with no sub-modules and buffer storage inline; its neighbours are the map table (downstream, consumes fl_pr0/fl_pr1) and the ROB (upstream retire, tags told).

Verification
REQ-022 Reset, then dispatch 2 valid -> fl_pr0=32, fl_pr1=33; next cycle fl_pr0=34, count=30.
REQ-023 dispatch_num=2, valid0=0, valid1=1 -> fl_pr1=32 (equals fl_pr0), head advances by 1, count=31.
REQ-024 Drain 32 tags, then retire 2 with told 5 and 9 -> next cycle fl_avail_num=2, fl_pr0=5, fl_pr1=9, tail wrapped to 2.
REQ-025 Allocate 6 tags, retire 2 (told 3, 4), then recover -> head=2, count=32, fl_pr0=34; retire inputs during the recover cycle are ignored.
REQ-026 Hold count=1 and in the same cycle retire 1 (told 7) while dispatching 2 -> with FL_BYPASS_EN fl_pr1=7 and count_next=0; without it fl_avail_num=1 and the bench stalls slot1.
REQ-027 Sustain 200 random legal cycles against a reference model -> tag sequences match, no duplicate tags outstanding, and count equals 32 minus in-flight allocations.
